// File: rtl/tri_subdivide_ctrl_pkg.sv
// rtl/tri_subdivide_ctrl_pkg.sv - shared triangle types, FSM states and extent helpers
// Contents: COORD_W, Point3D, Triangle3D, state_t, abs_diff, edge_extent, tri_extent, is_degenerate.
package tri_subdivide_ctrl_pkg;

    localparam int COORD_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_SPLIT_HI,
        S_SPLIT_LO,
        S_EMIT
    } state_t;

    // Unsigned distance; never goes through signed arithmetic.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Chebyshev length of one edge in the x/y plane; z does not matter to the rasterizer tiling.
    function automatic logic [COORD_W-1:0] edge_extent(input Point3D a, input Point3D b);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = abs_diff(a.x, b.x);
        dy = abs_diff(a.y, b.y);
        return (dx > dy) ? dx : dy;
    endfunction

    function automatic logic [COORD_W-1:0] tri_extent(input Triangle3D t);
        logic [COORD_W-1:0] e_pq;
        logic [COORD_W-1:0] e_qr;
        logic [COORD_W-1:0] e_rp;
        logic [COORD_W-1:0] m;
        e_pq = edge_extent(t.p, t.q);
        e_qr = edge_extent(t.q, t.r);
        e_rp = edge_extent(t.r, t.p);
        m    = (e_pq > e_qr) ? e_pq : e_qr;
        return (m > e_rp) ? m : e_rp;
    endfunction

    function automatic logic same_xy(input Point3D a, input Point3D b);
        return (a.x == b.x) && (a.y == b.y);
    endfunction

    function automatic logic is_degenerate(input Triangle3D t);
        return same_xy(t.p, t.q) || same_xy(t.q, t.r) || same_xy(t.r, t.p);
    endfunction

endpackage

// File: rtl/tri_subdivide_ctrl_if.sv
// rtl/tri_subdivide_ctrl_if.sv - input/output triangle valid/ready streams
// Signals: in_valid/in_ready/in_tri (upstream), out_valid/out_ready/out_tri (to rasterizer).
// Modports: master (environment side), slave (controller side).
interface tri_subdivide_ctrl_if;
    import tri_subdivide_ctrl_pkg::*;

    logic      in_valid;
    logic      in_ready;
    Triangle3D in_tri;
    logic      out_valid;
    logic      out_ready;
    Triangle3D out_tri;

    modport master (
        output in_valid, in_tri, out_ready,
        input  in_ready, out_valid, out_tri
    );

    modport slave (
        input  in_valid, in_tri, out_ready,
        output in_ready, out_valid, out_tri
    );

endinterface

// File: rtl/tri_subdivide_ctrl_stack.sv
// rtl/tri_subdivide_ctrl_stack.sv - tri_stack: DEPTH x Triangle3D LIFO of pending halves
// Ports: clk, n_rst (async active-low), push/din, pop, top (entry at sp-1), empty, full, sp.
module tri_stack
    import tri_subdivide_ctrl_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            push,
    input  logic            pop,
    input  Triangle3D       din,
    output Triangle3D       top,
    output logic            empty,
    output logic            full,
    output logic [SP_W-1:0] sp
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Triangle3D       mem_q [DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    logic            do_push, do_pop;
    logic [AW-1:0]   wr_idx, rd_idx;

    // Guards keep the pointer from wrapping even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = AW'(sp_q);
    assign rd_idx  = AW'(sp_q - SP_W'(1));

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Payload storage needs no reset: only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign top   = mem_q[rd_idx];
    assign empty = (sp_q == '0);
    assign full  = (sp_q == SP_W'(DEPTH));
    assign sp    = sp_q;

endmodule

// File: rtl/tri_subdivide_ctrl.sv
// rtl/tri_subdivide_ctrl.sv - depth-first recursive subdivision controller around bisect
// Ports: clk, n_rst (async active-low); sif slave stream (in_* accept, out_* emit);
//        bis_tri/bis_select to bisect, bis_out from bisect; busy; overflow (sticky until reset).
// Optional: DEGENERATE_CULL_EN drops pieces with two coincident x/y vertices instead of emitting.
module tri_subdivide_ctrl
    import tri_subdivide_ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int MIN_EDGE    = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    tri_subdivide_ctrl_if.slave  sif,
    output Triangle3D            bis_tri,
    output logic                 bis_select,
    input  Triangle3D            bis_out,
    output logic                 busy,
    output logic                 overflow
);
    localparam int                 SP_W       = $clog2(STACK_DEPTH + 1);
    localparam logic [COORD_W-1:0] MIN_EDGE_C = COORD_W'(MIN_EDGE);

    state_t          state_q, state_d;
    Triangle3D       cur_q, cur_d;
    logic            ovf_q, ovf_d;
    logic            stk_push, stk_pop, stk_empty, stk_full;
    Triangle3D       stk_top;
    logic [SP_W-1:0] stk_sp;

    tri_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (bis_out),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full),
        .sp    (stk_sp)
    );

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        ovf_d         = ovf_q;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        bis_select    = 1'b0;
        sif.in_ready  = 1'b0;
        sif.out_valid = 1'b0;
        sif.out_tri   = cur_q;
        case (state_q)
            S_IDLE: begin
                sif.in_ready = 1'b1;
                if (sif.in_valid) begin
                    cur_d   = sif.in_tri;
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
`ifdef DEGENERATE_CULL_EN
                if (is_degenerate(cur_q)) begin
                    if (stk_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        stk_pop = 1'b1;
                        cur_d   = stk_top;
                    end
                end else
`endif
                if (tri_extent(cur_q) <= MIN_EDGE_C) begin
                    state_d = S_EMIT;
                end else if (stk_sp == SP_W'(STACK_DEPTH)) begin
                    // No room to park the second half: emit this piece unsplit.
                    ovf_d   = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_SPLIT_HI;
                end
            end
            S_SPLIT_HI: begin
                // Second half is parked so the first half is refined first (pre-order).
                bis_select = 1'b1;
                stk_push   = !stk_full;
                state_d    = S_SPLIT_LO;
            end
            S_SPLIT_LO: begin
                cur_d   = bis_out;
                state_d = S_TEST;
            end
            S_EMIT: begin
                sif.out_valid = 1'b1;
                if (sif.out_ready) begin
                    if (stk_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        stk_pop = 1'b1;
                        cur_d   = stk_top;
                        state_d = S_TEST;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bis_tri  = cur_q;
    assign busy     = (state_q != S_IDLE);
    assign overflow = ovf_q;

endmodule
